xu_req_arb: RTL

//  Round-robin arbiter that shares one cross-unit (XU) master port among NM per-tile L2C XU

---
 rtl/xu_req_arb.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/xu_req_arb.sv
// xu_req_arb: round-robin arbiter that funnels NM per-tile XU masters into a
// single XU master port through a one-entry request buffer.
//
// Handshakes:
//  - Master side: a master raises m_req[i] with a stable payload and holds it
//    until it sees its one-cycle m_ack[i]; it drops m_req the cycle after.
//  - XU side: xu_req with a stable xu_* payload is held until xu_ack is
//    sampled high; the transfer completes on that edge. xu_ack is ignored
//    while xu_req is low.
// The FSM state is visible on the idle output (idle = state IDLE).
module xu_req_arb #(
   parameter  int NM     = 4,
   parameter  int CMD_W  = 2,
   parameter  int ADDR_W = 32,
   parameter  int UID_W  = 4,
   parameter  int TILE_W = 4,
   parameter  int DATA_W = 128,
   localparam int BE_W   = DATA_W / 8
) (
   input  logic                 clk,
   input  logic                 rst_,
   input  logic [NM-1:0]        m_req,
   input  logic [NM*CMD_W-1:0]  m_cmd,
   input  logic [NM*ADDR_W-1:0] m_addr,
   input  logic [NM*UID_W-1:0]  m_uid,
   input  logic [NM*TILE_W-1:0] m_src,
   input  logic [NM*BE_W-1:0]   m_data_be,
   input  logic [NM*DATA_W-1:0] m_data,
   output logic [NM-1:0]        m_ack,
   output logic                 xu_req,
   output logic [CMD_W-1:0]     xu_cmd,
   output logic [ADDR_W-1:0]    xu_addr,
   output logic [UID_W-1:0]     xu_uid,
   output logic [TILE_W-1:0]    xu_src,
   output logic [BE_W-1:0]      xu_data_be,
   output logic [DATA_W-1:0]    xu_data,
   input  logic                 xu_ack,
   input  logic                 drain,
   output logic                 idle,
   output logic [2:0]           grant_id
);

   localparam int PTR_W = (NM > 1) ? $clog2(NM) : 1;
   localparam int SUM_W = PTR_W + 1;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_BUSY = 1'b1
   } state_t;

   state_t           state;
   state_t           state_nx;
   logic [PTR_W-1:0] ptr;
   logic [PTR_W-1:0] ptr_nx;
   logic [PTR_W-1:0] pick;
   logic [PTR_W-1:0] cand;
   logic [SUM_W-1:0] sum;
   logic [NM-1:0]    mask;
   logic [NM-1:0]    elig;
   logic [NM-1:0]    ack_nx;
   logic             found;
   logic             grant;
   logic             release_buf;

   // The master acked on the previous edge may still show m_req this cycle.
   assign elig = m_req & ~mask;

   // Rotating-priority search: first eligible master at ptr, ptr+1, ... mod NM.
   always_comb begin
      found = 1'b0;
      pick  = '0;
      sum   = '0;
      cand  = '0;
      for (int k = 0; k < NM; k++) begin
         sum = {1'b0, ptr} + SUM_W'(k);
         if (sum >= SUM_W'(NM)) begin
            sum = sum - SUM_W'(NM);
         end
         cand = sum[PTR_W-1:0];
         if (!found && elig[cand]) begin
            found = 1'b1;
            pick  = cand;
         end
      end
   end

   // Pointer moves to the master after the winner, wrapping NM-1 -> 0.
   always_comb begin
      ptr_nx = ptr;
      if (grant) begin
         if (pick == PTR_W'(NM - 1)) begin
            ptr_nx = '0;
         end else begin
            ptr_nx = pick + PTR_W'(1);
         end
      end
   end

   // One-hot ack for the winner; also becomes the one-cycle mask.
   always_comb begin
      ack_nx = '0;
      if (grant) begin
         ack_nx[pick] = 1'b1;
      end
   end

   // Next-state logic: grants only from IDLE, drain holds off new grants,
   // BUSY waits for the XU to take the buffered request.
   always_comb begin
      state_nx    = state;
      grant       = 1'b0;
      release_buf = 1'b0;
      case (state)
         S_IDLE: begin
            if (!drain && found) begin
               grant    = 1'b1;
               state_nx = S_BUSY;
            end
         end
         S_BUSY: begin
            if (xu_ack) begin
               release_buf = 1'b1;
               state_nx    = S_IDLE;
            end
         end
         default: begin
            state_nx = S_IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         state <= S_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Round-robin pointer, ack pulse and regrant mask.
   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         ptr   <= '0;
         mask  <= '0;
         m_ack <= '0;
      end else begin
         ptr   <= ptr_nx;
         mask  <= ack_nx;
         m_ack <= ack_nx;
      end
   end

   // Downstream request flag: set on grant, cleared when the XU accepts.
   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         xu_req <= 1'b0;
      end else if (grant) begin
         xu_req <= 1'b1;
      end else if (release_buf) begin
         xu_req <= 1'b0;
      end
   end

   // Buffered payload and owner id, loaded only on a grant so they stay
   // stable for the whole time xu_req is high.
   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         xu_cmd     <= '0;
         xu_addr    <= '0;
         xu_uid     <= '0;
         xu_src     <= '0;
         xu_data_be <= '0;
         xu_data    <= '0;
         grant_id   <= '0;
      end else if (grant) begin
         xu_cmd     <= m_cmd[pick*CMD_W +: CMD_W];
         xu_addr    <= m_addr[pick*ADDR_W +: ADDR_W];
         xu_uid     <= m_uid[pick*UID_W +: UID_W];
         xu_src     <= m_src[pick*TILE_W +: TILE_W];
         xu_data_be <= m_data_be[pick*BE_W +: BE_W];
         xu_data    <= m_data[pick*DATA_W +: DATA_W];
         grant_id   <= 3'(pick);
      end
   end

   assign idle = (state == S_IDLE);

endmodule
